mem_port_arbiter: RTL and testbench



---
 rtl/mem_port_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port, fixed-latency memory between the
// instruction-fetch and data-memory stages. One access is in flight at a time;
// all memory-side outputs are registered. Data has priority over fetch unless
// fetch has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 30,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    output logic                  if_valid,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_stall,
    input  logic                  dm_rd_req,
    input  logic                  dm_wr_req,
    input  logic [ADDR_WIDTH-1:0] dm_addr,
    input  logic [DATA_WIDTH-1:0] dm_wdata,
    output logic                  dm_valid,
    output logic [DATA_WIDTH-1:0] dm_rdata,
    output logic                  dm_stall,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] LAT  = 4'(MEM_LATENCY);
    localparam logic [3:0] SLIM = 4'(STARVE_LIMIT);

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;   // 1 = data stage, 0 = fetch
    logic                  we_q, we_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [3:0]            starve_q, starve_d;
    logic                  mem_en_q, mem_en_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  if_valid_q, if_valid_d;
    logic                  dm_valid_q, dm_valid_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    logic                  grant_if, grant_dm;
    logic                  addr_err;

    // Arbitration: data first, fetch once starved; the requester finishing in RESP sits out
    always_comb begin
        logic arb_point;
        logic cand_if;
        logic cand_dm;
        arb_point = (state_q == IDLE) || (state_q == RESP);
        cand_if   = if_req & ~((state_q == RESP) & ~owner_q);
        cand_dm   = (dm_rd_req | dm_wr_req) & ~((state_q == RESP) & owner_q);
        grant_dm  = arb_point & cand_dm & ~(cand_if & (starve_q == SLIM));
        grant_if  = arb_point & cand_if & ~grant_dm;
    end

    // Protocol check: the winner's address must not move while its access is outstanding
    always_comb begin
        logic [ADDR_WIDTH-1:0] owner_addr;
        owner_addr = owner_q ? dm_addr : if_addr;
        addr_err   = ((state_q == ISSUE) || (state_q == WAIT)) && (owner_addr != mem_addr_q);
    end

    // Sequencer next state: latch winner, issue, count down latency, respond
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        starve_d    = starve_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_valid_d  = 1'b0;
        dm_valid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;

        case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (grant_dm || grant_if) begin
                    state_d     = ISSUE;
                    owner_d     = grant_dm;
                    // a simultaneous read+write request is treated as a write
                    we_d        = grant_dm & dm_wr_req;
                    mem_en_d    = 1'b1;
                    mem_we_d    = grant_dm & dm_wr_req;
                    mem_addr_d  = grant_dm ? dm_addr : if_addr;
                    mem_wdata_d = grant_dm ? dm_wdata : '0;
                end
                if (grant_if) begin
                    starve_d = '0;
                end else if (grant_dm && if_req && (starve_q != SLIM)) begin
                    starve_d = starve_q + 4'd1;
                end
            end
            ISSUE: begin
                cnt_d   = LAT;
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    if (owner_q) begin
                        dm_valid_d = 1'b1;
                        if (!we_q) dm_rdata_d = mem_rdata;
                    end else begin
                        if_valid_d = 1'b1;
                        if (!we_q) if_rdata_d = mem_rdata;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        err_d  = err_q | (dm_rd_req & dm_wr_req) | addr_err;
    end

    // State and output registers; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (rstb) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            starve_q    <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_valid_q  <= 1'b0;
            dm_valid_q  <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            starve_q    <= starve_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_valid_q  <= if_valid_d;
            dm_valid_q  <= dm_valid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign if_valid  = if_valid_q;
    assign dm_valid  = dm_valid_q;
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = busy_q;
    assign err       = err_q;

    // Stalls hold the requesting stage until the cycle its valid pulse appears
    assign if_stall  = if_req & ~if_valid_q;
    assign dm_stall  = (dm_rd_req | dm_wr_req) & ~dm_valid_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed and random requester traffic, a
// memory macro model, and a transaction-level reference model feeding a
// scoreboard that a negedge monitor checks against the DUT.
module tb_mem_port_arbiter;

    localparam int DW   = 32;
    localparam int AW   = 30;
    localparam int L    = 2;
    localparam int SL   = 2;
    localparam int MAXC = 4096;

    logic          clk = 1'b0;
    logic          rstb;
    logic          if_req, dm_rd_req, dm_wr_req;
    logic [AW-1:0] if_addr, dm_addr, mem_addr;
    logic [DW-1:0] dm_wdata, if_rdata, dm_rdata, mem_wdata, mem_rdata;
    logic          if_valid, if_stall, dm_valid, dm_stall;
    logic          mem_en, mem_we, busy, err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_LATENCY(L), .STARVE_LIMIT(SL)
    ) dut (
        .clk(clk), .rstb(rstb),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_rd_req(dm_rd_req), .dm_wr_req(dm_wr_req), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_valid(dm_valid), .dm_rdata(dm_rdata),
        .dm_stall(dm_stall),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .err(err)
    );

    typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata; } iss_t;
    typedef struct { int cyc; logic dm; logic we; logic [DW-1:0] rdata; } rsp_t;
    typedef struct { int cyc; logic [5:0] idx; } pend_t;

    iss_t  iss_q[$];
    rsp_t  rsp_q[$];
    pend_t pend_q[$];

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [DW-1:0] tb_mem  [64];   // memory macro contents
    logic [DW-1:0] ref_mem [64];   // reference model's view of memory
    bit            exp_busy [MAXC];
    bit            exp_err  [MAXC];

    // reference model state
    bit            m_busy = 0;
    int            m_resp, m_g;
    bit            m_own;
    logic [AW-1:0] m_addr;
    int            starve = 0;

    // requester intents
    bit            rand_mode = 0;
    bit            f_act = 0, f_done = 0, d_act = 0, d_done = 0;
    int            d_kind = 0;    // 0 read, 1 write, 2 read+write
    logic [AW-1:0] f_addr = '0, d_addr = '0;
    logic [DW-1:0] d_wdata = '0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
    endfunction

    function automatic logic [AW-1:0] rnd_addr();
        logic [31:0] r;
        r = $urandom;
        return r[AW-1:0];
    endfunction

    function automatic void set_err(int from);
        for (int k = from; k < MAXC; k++) exp_err[k] = 1'b1;
    endfunction

    // Transaction-level model: a grant at cycle g issues at g+1, samples memory
    // at g+1+L and responds at g+2+L, where the next decision is taken.
    function automatic void model_cycle(int c);
        bit ign_f, ign_d, cf, cd, pick_d, we;
        logic [AW-1:0] a;
        logic [DW-1:0] rd;
        if (rstb) begin
            while (iss_q.size() > 0 && iss_q[$].cyc > c) void'(iss_q.pop_back());
            while (rsp_q.size() > 0 && rsp_q[$].cyc > c) void'(rsp_q.pop_back());
            for (int k = c + 1; k < MAXC; k++) begin exp_busy[k] = 1'b0; exp_err[k] = 1'b0; end
            m_busy = 0; starve = 0;
            return;
        end
        if (dm_rd_req && dm_wr_req) set_err(c + 1);
        if (m_busy && c >= m_g + 1 && c <= m_g + 1 + L) begin
            a = m_own ? dm_addr : if_addr;
            if (a != m_addr) set_err(c + 1);
        end
        if (!m_busy || c == m_resp) begin
            ign_f = m_busy && !m_own;
            ign_d = m_busy && m_own;
            if (m_busy) begin
                if (m_own) d_done = 1; else f_done = 1;
                m_busy = 0;
            end
            cf = if_req && !ign_f;
            cd = (dm_rd_req || dm_wr_req) && !ign_d;
            if (cf || cd) begin
                pick_d = cd && !(cf && starve == SL);
                if (!pick_d) starve = 0;
                else if (if_req && starve < SL) starve++;
                we = pick_d && dm_wr_req;
                a  = pick_d ? dm_addr : if_addr;
                rd = ref_mem[a[5:0]];
                if (we) ref_mem[a[5:0]] = dm_wdata;
                iss_q.push_back('{cyc: c + 1, we: we, addr: a, wdata: dm_wdata});
                rsp_q.push_back('{cyc: c + 2 + L, dm: pick_d, we: we, rdata: rd});
                for (int k = c + 1; k <= c + 2 + L && k < MAXC; k++) exp_busy[k] = 1'b1;
                m_busy = 1; m_resp = c + 2 + L; m_own = pick_d; m_g = c; m_addr = a;
            end
        end
    endfunction

    // Random requesters: hold until valid, may chain; fetch is occasionally flushed while waiting
    function automatic void rand_update();
        bit lock_f, lock_d;
        logic [31:0] r;
        lock_f = m_busy && !m_own;
        lock_d = m_busy && m_own;
        if (f_done) begin
            f_done = 0; f_act = ($urandom % 4) != 0; f_addr = rnd_addr();
        end else if (!f_act) begin
            if ($urandom % 3 == 0) begin f_act = 1; f_addr = rnd_addr(); end
        end else if (!lock_f && ($urandom % 8 == 0)) begin
            f_act = 0;
        end
        if (d_done || (!d_act && !lock_d && ($urandom % 3 == 0))) begin
            d_act = d_done ? (($urandom % 4) != 0) : 1'b1;
            d_done = 0; d_kind = int'($urandom % 2); d_addr = rnd_addr();
            r = $urandom; d_wdata = r;
        end
    endfunction

    task automatic step(input logic rst);
        @(posedge clk);
        #1;
        rstb = rst;
        if (rst) begin
            f_act = 0; d_act = 0; f_done = 0; d_done = 0;
        end else if (rand_mode) begin
            rand_update();
        end else begin
            if (f_done) begin f_done = 0; f_act = 0; end
            if (d_done) begin d_done = 0; d_act = 0; end
        end
        if_req    = f_act;
        if_addr   = f_addr;
        dm_rd_req = d_act && (d_kind != 1);
        dm_wr_req = d_act && (d_kind != 0);
        dm_addr   = d_addr;
        dm_wdata  = d_wdata;
        model_cycle(cyc);
    endtask

    // Memory macro: returns read data exactly L cycles after issue, junk otherwise
    always @(negedge clk) begin
        if (mem_en) begin
            if (mem_we) tb_mem[mem_addr[5:0]] = mem_wdata;
            else pend_q.push_back('{cyc: cyc + L, idx: mem_addr[5:0]});
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            while (pend_q.size() > 0 && pend_q[0].cyc < cyc) void'(pend_q.pop_front());
            if (pend_q.size() > 0 && pend_q[0].cyc == cyc) mem_rdata = tb_mem[pend_q.pop_front().idx];
            else mem_rdata = $urandom;
        end
    end

    // Monitor: pops scoreboard entries as the DUT presents issues and responses
    logic [DW-1:0] held_if = '0, held_dm = '0;
    logic          rst_prev = 1'b1;
    initial begin
        forever begin
            @(negedge clk);
            begin
                bit e_en, e_if, e_dm;
                if (rst_prev) begin held_if = '0; held_dm = '0; end
                while (iss_q.size() > 0 && iss_q[0].cyc < cyc) begin
                    chk("issue_missing", 0, 1); void'(iss_q.pop_front());
                end
                while (rsp_q.size() > 0 && rsp_q[0].cyc < cyc) begin
                    chk("resp_missing", 0, 1); void'(rsp_q.pop_front());
                end
                e_en = iss_q.size() > 0 && iss_q[0].cyc == cyc;
                chk("mem_en", mem_en, e_en);
                if (e_en) begin
                    chk("mem_addr", mem_addr, iss_q[0].addr);
                    chk("mem_we", mem_we, iss_q[0].we);
                    if (iss_q[0].we) chk("mem_wdata", mem_wdata, iss_q[0].wdata);
                    void'(iss_q.pop_front());
                end
                e_if = rsp_q.size() > 0 && rsp_q[0].cyc == cyc && !rsp_q[0].dm;
                e_dm = rsp_q.size() > 0 && rsp_q[0].cyc == cyc && rsp_q[0].dm;
                chk("if_valid", if_valid, e_if);
                chk("dm_valid", dm_valid, e_dm);
                if (e_if || e_dm) begin
                    if (!rsp_q[0].we) begin
                        if (e_if) held_if = rsp_q[0].rdata;
                        else held_dm = rsp_q[0].rdata;
                    end
                    void'(rsp_q.pop_front());
                end
                chk("if_rdata", if_rdata, held_if);
                chk("dm_rdata", dm_rdata, held_dm);
                chk("if_stall", if_stall, if_req && !e_if);
                chk("dm_stall", dm_stall, (dm_rd_req || dm_wr_req) && !e_dm);
                chk("busy", busy, (cyc < MAXC) ? exp_busy[cyc] : 1'b0);
                chk("err", err, (cyc < MAXC) ? exp_err[cyc] : 1'b0);
                rst_prev = rstb;
            end
        end
    end

    initial begin
        rstb = 1'b1; if_req = 0; dm_rd_req = 0; dm_wr_req = 0;
        if_addr = '0; dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
        for (int i = 0; i < 64; i++) begin
            tb_mem[i] = $urandom; ref_mem[i] = tb_mem[i];
        end
        repeat (3) step(1);
        repeat (2) step(0);

        // fetch only: 0x10 returns 0xDEADBEEF
        tb_mem[6'h10] = 32'hDEADBEEF; ref_mem[6'h10] = 32'hDEADBEEF;
        f_act = 1; f_addr = 30'h10;
        repeat (8) step(0);

        // simultaneous fetch and load: data first, fetch at RESP+1
        f_act = 1; f_addr = 30'h11;
        d_act = 1; d_kind = 0; d_addr = 30'h12;
        repeat (12) step(0);

        // store 0x1234 to 0x20; dm_rdata must keep the previous load value
        d_act = 1; d_kind = 1; d_addr = 30'h20; d_wdata = 32'h1234;
        repeat (7) step(0);

        // random traffic, then drain
        rand_mode = 1;
        repeat (900) step(0);
        rand_mode = 0;
        repeat (40) step(0);

        // reset in WAIT: access aborted, no valid pulse afterwards
        d_act = 1; d_kind = 0; d_addr = 30'h5;
        step(0); step(0); step(1);
        repeat (8) step(0);

        // read+write together: treated as a write, err sticks until reset
        d_act = 1; d_kind = 2; d_addr = 30'h21; d_wdata = 32'hCAFE0001;
        repeat (10) step(0);
        step(1);
        repeat (3) step(0);

        // address moves while the access is outstanding
        d_act = 1; d_kind = 0; d_addr = 30'h22;
        step(0); step(0);
        d_addr = 30'h23;
        repeat (8) step(0);
        step(1);
        repeat (4) step(0);

        @(negedge clk);
        chk("issue_queue_drained", iss_q.size(), 0);
        chk("resp_queue_drained", rsp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
